nn_layer_seq: RTL and testbench

NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

---
 rtl/nn_layer_seq.sv | 215 +++++++++++++++++++++
 tb/tb_nn_layer_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_seq.sv
// nn_layer_seq: sequences a 4-phase req/ack handshake over a chain of layer
// engines and forwards weight writes. Optional watchdog: NN_SEQ_TIMEOUT_EN.
module nn_layer_seq #(
  parameter int NumLayers     = 3,
  parameter int AddrWidth     = 6,
  parameter int DataWidth     = 8,
  parameter int CntWidth      = 16,
  parameter int TimeoutCycles = 1024,
  localparam int LW           = $clog2(NumLayers) + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 continuous_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LW-1:0]        cur_layer_o,
  output logic [NumLayers-1:0] layer_req_o,
  input  logic [NumLayers-1:0] layer_ack_i,
  input  logic [LW-1:0]        wgt_sel_i,
  input  logic                 wgt_we_i,
  input  logic [AddrWidth-1:0] wgt_addr_i,
  input  logic [DataWidth-1:0] wgt_din_i,
  output logic [NumLayers-1:0] wgt_we_o,
  output logic [AddrWidth-1:0] wgt_addr_o,
  output logic [DataWidth-1:0] wgt_din_o,
  output logic                 wgt_err_o,
  output logic [CntWidth-1:0]  cycle_cnt_o,
  output logic [CntWidth-1:0]  frame_cnt_o,
  output logic                 timeout_o
);

  if (NumLayers < 1 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("nn_layer_seq: NumLayers and TimeoutCycles must be >= 1");
  end

`ifdef NN_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_REL, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_REL, S_DONE
  } state_t;
`endif

  state_t state_q, state_d;
  logic [LW-1:0] cur_q, cur_d;
  logic [CntWidth-1:0] run_q, cyc_q, frm_q;
  logic ack_sel, last, idle_ish, busy;
  logic start_acc, go_start, enter_done;
  logic wr_acc, wr_rej;
  logic [NumLayers-1:0] sel_dec, we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] din_q;
  logic err_q;

`ifdef NN_SEQ_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd_q;
  logic wd_hit, to_q, enter_err;
  assign wd_hit    = (wd_q == WdW'(TimeoutCycles - 1));
  assign enter_err = (state_d == S_ERR) && (state_q != S_ERR);
`endif

  assign idle_ish   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy       = (state_q == S_REQ) || (state_q == S_REL);
  assign last       = (cur_q == LW'(NumLayers - 1));
  assign start_acc  = start_i && idle_ish;
  assign go_start   = idle_ish && (state_d == S_REQ);
  assign enter_done = (state_q == S_REL) && (state_d == S_DONE);
  assign wr_acc     = wgt_we_i && idle_ish &&
                      (wgt_sel_i < LW'(NumLayers));
  assign wr_rej     = wgt_we_i && !wr_acc;

  // Select the current layer's ack, drive its req, decode write target
  always_comb begin
    ack_sel     = 1'b0;
    sel_dec     = '0;
    layer_req_o = '0;
    for (int i = 0; i < NumLayers; i++) begin
      if (cur_q == LW'(i)) begin
        ack_sel        = layer_ack_i[i];
        layer_req_o[i] = (state_q == S_REQ);
      end
      if (wgt_sel_i == LW'(i)) sel_dec[i] = 1'b1;
    end
  end

  // Next-state logic for the handshake sequencer
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          cur_d   = '0;
        end
      end
      S_REQ: begin
        if (ack_sel) state_d = S_REL;
`ifdef NN_SEQ_TIMEOUT_EN
        else if (wd_hit) state_d = S_ERR;
`endif
      end
      S_REL: begin
        if (!ack_sel) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            cur_d   = cur_q + LW'(1);
          end
        end
`ifdef NN_SEQ_TIMEOUT_EN
        else if (wd_hit) state_d = S_ERR;
`endif
      end
      S_DONE: begin
        if (start_i || continuous_i) begin
          state_d = S_REQ;
          cur_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef NN_SEQ_TIMEOUT_EN
      S_ERR: begin
        if (clear_i) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and layer index registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  // Running frame length, latched length and frame count (saturating)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_q <= '0;
      cyc_q <= '0;
      frm_q <= '0;
    end else begin
      if (go_start) run_q <= CntWidth'(1);
      else if (busy && run_q != '1) run_q <= run_q + CntWidth'(1);
      if (enter_done) begin
        cyc_q <= run_q;
        if (frm_q != '1) frm_q <= frm_q + CntWidth'(1);
      end
    end
  end

  // Registered weight write port; rejected writes never strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= wr_acc ? sel_dec : '0;
      if (wr_acc) begin
        addr_q <= wgt_addr_i;
        din_q  <= wgt_din_i;
      end
    end
  end

  // Sticky rejected-write flag; a fresh rejection wins over a clear
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else if (wr_rej) err_q <= 1'b1;
    else if (clear_i || start_acc) err_q <= 1'b0;
  end

`ifdef NN_SEQ_TIMEOUT_EN
  // Watchdog restarts on every phase change, flag is sticky until clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (!busy || state_d != state_q) wd_q <= '0;
      else if (!wd_hit) wd_q <= wd_q + WdW'(1);
      if (clear_i) to_q <= 1'b0;
      else if (enter_err) to_q <= 1'b1;
    end
  end
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o      = busy;
  assign done_o      = (state_q == S_DONE);
  assign cur_layer_o = cur_q;
  assign wgt_we_o    = we_q;
  assign wgt_addr_o  = addr_q;
  assign wgt_din_o   = din_q;
  assign wgt_err_o   = err_q;
  assign cycle_cnt_o = cyc_q;
  assign frame_cnt_o = frm_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq: directed + randomized checks of nn_layer_seq against
// a behavioural model (busy-cycle measurement, done counting, write rules).
`define CHK(tag, o, e) \
  begin \
    checks++; \
    assert (32'(o) === 32'(e)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e); \
    end \
  end

module tb_nn_layer_seq;
  localparam int NL   = 3;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int CW   = 5;
  localparam int TO   = 8;
  localparam int LW   = $clog2(NL) + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, start_i, continuous_i, clear_i;
  logic          busy_o, done_o, wgt_we_i, wgt_err_o, timeout_o;
  logic [LW-1:0] cur_layer_o, wgt_sel_i;
  logic [NL-1:0] layer_req_o, layer_ack_i, wgt_we_o;
  logic [AW-1:0] wgt_addr_i, wgt_addr_o;
  logic [DW-1:0] wgt_din_i, wgt_din_o;
  logic [CW-1:0] cycle_cnt_o, frame_cnt_o;

  nn_layer_seq #(
    .NumLayers(NL), .AddrWidth(AW), .DataWidth(DW),
    .CntWidth(CW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .continuous_i(continuous_i), .clear_i(clear_i),
    .busy_o(busy_o), .done_o(done_o), .cur_layer_o(cur_layer_o),
    .layer_req_o(layer_req_o), .layer_ack_i(layer_ack_i),
    .wgt_sel_i(wgt_sel_i), .wgt_we_i(wgt_we_i),
    .wgt_addr_i(wgt_addr_i), .wgt_din_i(wgt_din_i),
    .wgt_we_o(wgt_we_o), .wgt_addr_o(wgt_addr_o),
    .wgt_din_o(wgt_din_o), .wgt_err_o(wgt_err_o),
    .cycle_cnt_o(cycle_cnt_o), .frame_cnt_o(frame_cnt_o),
    .timeout_o(timeout_o)
  );

  int checks = 0;
  int failures = 0;

  // layer engine model knobs
  bit resp_en = 0;
  bit noise_en = 0;
  int rmin = 0, rmax = 0, fmin = 0, fmax = 0;
  int rph = 0, rc = 0, rl = 0;
  logic [NL-1:0] ack_r = '0;
  int visited[$];

  // monitor state
  int busy_run = 0, last_len = 0, done_cnt = 0, bad_req = 0;

  // Layer engine: ack after a random delay, drop it after req falls
  always @(negedge clk) begin
    if (!resp_en) begin
      rph = 0;
      ack_r = '0;
    end else begin
      case (rph)
        0: if (|layer_req_o) begin
          for (int i = 0; i < NL; i++) if (layer_req_o[i]) rl = i;
          visited.push_back(rl);
          rc = $urandom_range(rmax, rmin);
          rph = 1;
        end
        1: if (rc == 0) begin ack_r[rl] = 1'b1; rph = 2; end
           else rc--;
        2: if (!layer_req_o[rl]) begin
          rc = $urandom_range(fmax, fmin);
          rph = 3;
        end
        3: if (rc == 0) begin ack_r[rl] = 1'b0; rph = 0; end
           else rc--;
        default: rph = 0;
      endcase
    end
    if (noise_en)
      layer_ack_i = ack_r | (NL'($urandom) & ~(NL'(1) << cur_layer_o));
    else
      layer_ack_i = ack_r;
  end

  // Monitor: busy cycles per frame, done pulses, req legality
  always @(negedge clk) begin
    if (reset_i) begin
      busy_run = 0;
      last_len = 0;
      done_cnt = 0;
    end else begin
      if (busy_o) busy_run++;
      if (done_o) begin
        done_cnt++;
        last_len = busy_run;
        busy_run = 0;
      end
    end
    if (layer_req_o != '0) begin
      if (!busy_o) bad_req++;
      if (layer_req_o != (NL'(1) << cur_layer_o)) bad_req++;
    end
  end

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    bit ok;
    int v0, d0, k, n;
    bit acc, err_m;
    logic [NL-1:0] exp_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [LW-1:0] es;

    reset_i = 1'b1; start_i = 1'b0; continuous_i = 1'b0;
    clear_i = 1'b0; wgt_we_i = 1'b0; wgt_sel_i = '0;
    wgt_addr_i = '0; wgt_din_i = '0; layer_ack_i = '0;
    repeat (3) step();
    `CHK("rst_busy", busy_o, 1'b0)
    `CHK("rst_done", done_o, 1'b0)
    `CHK("rst_req", layer_req_o, 3'b000)
    `CHK("rst_cur", cur_layer_o, 3'd0)
    `CHK("rst_we", wgt_we_o, 3'b000)
    `CHK("rst_err", wgt_err_o, 1'b0)
    `CHK("rst_cyc", cycle_cnt_o, 5'd0)
    `CHK("rst_frm", frame_cnt_o, 5'd0)
    `CHK("rst_to", timeout_o, 1'b0)
    reset_i = 1'b0;
    step();

    // single frame, fixed ack timing
    resp_en = 1; rmin = 1; rmax = 1; fmin = 0; fmax = 0;
    v0 = visited.size(); d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, ok);
    `CHK("f1_finish", ok, 1'b1)
    repeat (3) step();
    `CHK("f1_nvisit", visited.size() - v0, 3)
    `CHK("f1_l0", visited[v0], 0)
    `CHK("f1_l1", visited[v0 + 1], 1)
    `CHK("f1_l2", visited[v0 + 2], 2)
    `CHK("f1_ndone", done_cnt - d0, 1)
    `CHK("f1_frm", frame_cnt_o, 5'd1)
    `CHK("f1_cyc", cycle_cnt_o, sat(last_len))
    `CHK("f1_busy", busy_o, 1'b0)

    // start while busy is ignored
    d0 = done_cnt;
    pulse_start();
    step();
    `CHK("ign_busy", busy_o, 1'b1)
    pulse_start();
    wait_done(d0 + 1, ok);
    repeat (8) step();
    `CHK("ign_ndone", done_cnt - d0, 1)
    `CHK("ign_frm", frame_cnt_o, sat(done_cnt))

    // continuous mode for three frames
    d0 = done_cnt; k = 0;
    continuous_i = 1'b1;
    pulse_start();
    for (int i = 0; i < 1000 && k < 3; i++) begin
      if (done_o) begin
        k++;
        if (k == 3) continuous_i = 1'b0;
      end
      if (k < 3) step();
    end
    continuous_i = 1'b0;
    repeat (5) step();
    `CHK("cont_ndone", done_cnt - d0, 3)
    `CHK("cont_frm", frame_cnt_o, sat(done_cnt))
    `CHK("cont_cyc", cycle_cnt_o, sat(last_len))
    `CHK("cont_idle", busy_o, 1'b0)

    // randomized frames with noise on unselected acks
    noise_en = 1;
    for (int t = 0; t < 6; t++) begin
      rmin = 0; rmax = $urandom_range(8, 0);
      fmin = 0; fmax = $urandom_range(4, 0);
      d0 = done_cnt;
      pulse_start();
      wait_done(d0 + 1, ok);
      step();
      `CHK("rnd_finish", ok, 1'b1)
      `CHK("rnd_frm", frame_cnt_o, sat(done_cnt))
      `CHK("rnd_cyc", cycle_cnt_o, sat(last_len))
    end
    noise_en = 0;

    // slow frame: cycle count saturates
    rmin = 12; rmax = 12; fmin = 2; fmax = 2;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, ok);
    step();
    `CHK("slow_len", last_len > MAXC, 1'b1)
    `CHK("slow_cyc", cycle_cnt_o, sat(last_len))

    // many frames: frame count saturates
    rmin = 0; rmax = 0; fmin = 0; fmax = 0;
    continuous_i = 1'b1;
    pulse_start();
    for (int i = 0; i < 5000 && done_cnt < MAXC + 3; i++) step();
    continuous_i = 1'b0;
    repeat (5) step();
    `CHK("sat_ndone", done_cnt >= MAXC + 3, 1'b1)
    `CHK("sat_frm", frame_cnt_o, sat(done_cnt))

    // weight write accepted in idle
    wgt_we_i = 1'b1; wgt_sel_i = 3'd1;
    wgt_addr_i = 6'd5; wgt_din_i = 8'hA5;
    step();
    wgt_we_i = 1'b0;
    `CHK("w_we", wgt_we_o, 3'b010)
    `CHK("w_addr", wgt_addr_o, 6'd5)
    `CHK("w_din", wgt_din_o, 8'hA5)
    `CHK("w_err", wgt_err_o, 1'b0)
    step();
    `CHK("w_pulse", wgt_we_o, 3'b000)

    // out-of-range select rejected, flag sticky until clear
    wgt_we_i = 1'b1; wgt_sel_i = 3'd3;
    step();
    wgt_we_i = 1'b0;
    `CHK("wr_we", wgt_we_o, 3'b000)
    `CHK("wr_err", wgt_err_o, 1'b1)
    step();
    `CHK("wr_sticky", wgt_err_o, 1'b1)
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    `CHK("wr_clear", wgt_err_o, 1'b0)

    // write while busy rejected
    d0 = done_cnt;
    pulse_start();
    `CHK("wb_busy", busy_o, 1'b1)
    wgt_we_i = 1'b1; wgt_sel_i = 3'd1;
    step();
    wgt_we_i = 1'b0;
    `CHK("wb_we", wgt_we_o, 3'b000)
    `CHK("wb_err", wgt_err_o, 1'b1)
    wait_done(d0 + 1, ok);
    step();
    `CHK("wb_keep", wgt_err_o, 1'b1)

    // write and start in the same idle cycle
    d0 = done_cnt;
    wgt_we_i = 1'b1; wgt_sel_i = 3'd2;
    wgt_addr_i = 6'd9; wgt_din_i = 8'h3C;
    start_i = 1'b1;
    step();
    wgt_we_i = 1'b0; start_i = 1'b0;
    `CHK("ws_we", wgt_we_o, 3'b100)
    `CHK("ws_addr", wgt_addr_o, 6'd9)
    `CHK("ws_din", wgt_din_o, 8'h3C)
    `CHK("ws_busy", busy_o, 1'b1)
    `CHK("ws_errclr", wgt_err_o, 1'b0)
    wait_done(d0 + 1, ok);
    step();

    // random writes in idle
    err_m = 1'b0;
    for (int t = 0; t < 8; t++) begin
      es = LW'($urandom_range(3, 0));
      ea = AW'($urandom);
      ed = DW'($urandom);
      acc = (es < 3);
      exp_we = acc ? (NL'(1) << es) : '0;
      err_m = err_m | !acc;
      wgt_we_i = 1'b1; wgt_sel_i = es;
      wgt_addr_i = ea; wgt_din_i = ed;
      step();
      wgt_we_i = 1'b0;
      `CHK("rw_we", wgt_we_o, exp_we)
      `CHK("rw_err", wgt_err_o, err_m)
      if (acc) begin
        `CHK("rw_addr", wgt_addr_o, ea)
        `CHK("rw_din", wgt_din_o, ed)
      end
    end

    // reset during layer 1 request
    rmin = 2; rmax = 2; fmin = 0; fmax = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (layer_req_o[1]) begin ok = 1'b1; break; end
      step();
    end
    `CHK("mr_reach", ok, 1'b1)
    reset_i = 1'b1; resp_en = 0;
    step();
    `CHK("mr_req", layer_req_o, 3'b000)
    `CHK("mr_busy", busy_o, 1'b0)
    `CHK("mr_cyc", cycle_cnt_o, 5'd0)
    `CHK("mr_frm", frame_cnt_o, 5'd0)
    `CHK("mr_err", wgt_err_o, 1'b0)
    `CHK("mr_cur", cur_layer_o, 3'd0)
    reset_i = 1'b0;
    step();

    // ack never arrives
    pulse_start();
`ifdef NN_SEQ_TIMEOUT_EN
    n = busy_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (timeout_o) break;
      if (busy_o) n++;
    end
    `CHK("to_cycles", n, TO)
    `CHK("to_flag", timeout_o, 1'b1)
    `CHK("to_busy", busy_o, 1'b0)
    `CHK("to_req", layer_req_o, 3'b000)
    pulse_start();
    step();
    `CHK("to_ign_start", busy_o, 1'b0)
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    `CHK("to_clear", timeout_o, 1'b0)
    resp_en = 1; rmin = 0; rmax = 0;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, ok);
    `CHK("to_recover", ok, 1'b1)
`else
    n = 0;
    repeat (30) step();
    `CHK("hang_busy", busy_o, 1'b1)
    `CHK("hang_req", layer_req_o, 3'b001)
    `CHK("hang_to", timeout_o, 1'b0)
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    `CHK("hang_rst", busy_o, 1'b0)
`endif
    step();
    `CHK("req_legal", bad_req, 0)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
